// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters that stall issue on
// RAW hazards and on counter saturation, with flush and a sticky underflow flag.
module reg_scoreboard #(
    parameter int NREG    = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic              iss_src1_en,
    input  logic [ADDR_W-1:0] iss_src1,
    input  logic              iss_src2_en,
    input  logic [ADDR_W-1:0] iss_src2,
    input  logic              iss_we,
    input  logic [ADDR_W-1:0] iss_dest,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              flush,
    output logic [NREG-1:0]   busy_vec,
    output logic              hazard1,
    output logic              hazard2,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] r_cnt [NREG];
    logic             r_err;

    logic [CNT_W-1:0] w_cnt_src1, w_cnt_src2, w_cnt_dest, w_cnt_wb;
    logic             w_src1_trk, w_src2_trk, w_dest_trk, w_wb_trk;
    logic             w_accept, w_inc_any, w_underflow;
    logic [NREG-1:0]  w_inc, w_dec;

    function automatic logic f_tracked(input logic [ADDR_W-1:0] x);
        return (int'(x) < NREG) && !((R0_ZERO != 0) && (x == '0));
    endfunction

    // Untracked indices read as an idle counter so they never hazard or block.
    always_comb begin
        w_src1_trk = f_tracked(iss_src1);
        w_src2_trk = f_tracked(iss_src2);
        w_dest_trk = f_tracked(iss_dest);
        w_wb_trk   = f_tracked(wb_dest);
        w_cnt_src1 = '0;
        w_cnt_src2 = '0;
        w_cnt_dest = '0;
        w_cnt_wb   = '0;
        if (w_src1_trk) w_cnt_src1 = r_cnt[iss_src1];
        if (w_src2_trk) w_cnt_src2 = r_cnt[iss_src2];
        if (w_dest_trk) w_cnt_dest = r_cnt[iss_dest];
        if (w_wb_trk)   w_cnt_wb   = r_cnt[wb_dest];
    end

    assign hazard1   = iss_src1_en && (w_cnt_src1 != '0);
    assign hazard2   = iss_src2_en && (w_cnt_src2 != '0);
    assign iss_ready = !hazard1 && !hazard2 && !flush &&
                       !(iss_we && w_dest_trk && (w_cnt_dest == CMAX));
    assign w_accept  = iss_valid && iss_ready;
    assign w_inc_any = w_accept && iss_we && w_dest_trk;

    // A retire to an idle register is absorbed silently when it pairs with a same-cycle issue.
    assign w_underflow = wb_valid && w_wb_trk && (w_cnt_wb == '0) &&
                         !(w_inc_any && (iss_dest == wb_dest));

    always_comb begin
        w_inc    = '0;
        w_dec    = '0;
        busy_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            w_inc[r]    = w_inc_any && (int'(iss_dest) == r);
            w_dec[r]    = wb_valid && w_wb_trk && (int'(wb_dest) == r);
            busy_vec[r] = (r_cnt[r] != '0) && !((R0_ZERO != 0) && (r == 0));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
            r_err <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_inc[r] && !w_dec[r])
                    r_cnt[r] <= r_cnt[r] + 1'b1;
                else if (!w_inc[r] && w_dec[r] && (r_cnt[r] != '0))
                    r_cnt[r] <= r_cnt[r] - 1'b1;
            end
            if (w_underflow) r_err <= 1'b1;
        end
    end

    assign err_underflow = r_err;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of tracked architectural registers (34 when HI/LO are tracked as regs 32/33).
REQ-002 SHALL have parameter ADDR_W, default 5 (6 when NREG>32), register-index width.
REQ-003 SHALL have parameter CNT_W, default 2, per-register outstanding-write counter width; CMAX = 2^CNT_W-1.
REQ-004 SHALL have parameter R0_ZERO, default 1; when 1, register 0 is hardwired zero and never tracked.
REQ-005 SHALL have the following ports, one clock with asynchronous active-low reset:
 clk  in  1  rising-edge clock
 resetn  in  1  asynchronous active-low reset
 iss_valid  in  1  decode presents an instruction for issue
 iss_ready  out  1  scoreboard permits issue this cycle
 iss_src1_en  in  1  source 1 is a real register read
 iss_src1  in  ADDR_W  source 1 index
 iss_src2_en  in  1  source 2 is a real register read
 iss_src2  in  ADDR_W  source 2 index
 iss_we  in  1  instruction writes iss_dest
 iss_dest  in  ADDR_W  destination index
 wb_valid  in  1  a tracked write retires this cycle
 wb_dest  in  ADDR_W  retiring destination index
 flush  in  1  clear all tracking (pipeline drained by exception/eret)
 busy_vec  out  NREG  bit r = register r has outstanding write
 hazard1  out  1  source 1 blocked
 hazard2  out  1  source 2 blocked
 err_underflow  out  1  sticky: retire seen on idle register

Function
REQ-006 SHALL hold one CNT_W-bit counter cnt[r] per register r in 0..NREG-1.
REQ-007 SHALL define tracked(x) = (x < NREG) and not (R0_ZERO and x == 0); untracked indices never hazard, increment or decrement.
REQ-008 SHALL drive hazardN = iss_srcN_en and tracked(iss_srcN) and cnt[iss_srcN] != 0, combinationally from current counters; no same-cycle writeback bypass.
REQ-009 SHALL drive iss_ready = !hazard1 and !hazard2 and !(iss_we and tracked(iss_dest) and cnt[iss_dest] == CMAX) and !flush.
REQ-010 SHALL define accept = iss_valid and iss_ready; iss_ready SHALL NOT depend on iss_valid.
REQ-011 SHALL on accept with iss_we and tracked(iss_dest) increment cnt[iss_dest] at the next edge.
REQ-012 SHALL on wb_valid, tracked(wb_dest), cnt[wb_dest] != 0 decrement cnt[wb_dest] at the next edge.
REQ-013 SHALL, when increment and decrement target the same register in one cycle, leave that counter unchanged (including at CMAX and at 0).
REQ-014 SHALL on wb_valid to a tracked register with cnt 0 (and no same-cycle increment to it) leave the counter at 0 and set err_underflow at the next edge.
REQ-015 SHALL, when increment and decrement target different registers, apply both in the same cycle.
REQ-016 SHALL on flush clear every counter and err_underflow at the next edge, ignoring same-cycle issue and wb_valid.
REQ-017 SHALL drive busy_vec[r] = (cnt[r] != 0) combinationally from registered counters; busy_vec[0] = 0 when R0_ZERO.
REQ-018 SHALL never wrap a counter: saturation at CMAX is prevented by REQ-009, at 0 by REQ-014.

Reset
REQ-019 SHALL on resetn low, asynchronously and independent of clk, clear all counters and err_underflow.
REQ-020 SHALL during reset drive busy_vec = 0, hazard1 = hazard2 = 0, err_underflow = 0, iss_ready = 1 (flush low).
REQ-021 SHALL resume tracking on the first rising edge after resetn deasserts; reset mid-operation discards all outstanding state.

Verification
REQ-022 SHALL cover RAW stall: issue we dest=5, next cycle src1=5 -> hazard1=1, iss_ready=0; wb_valid dest=5 -> next cycle hazard1=0, iss_ready=1.
REQ-023 SHALL cover saturation (CNT_W=2): three accepted writes to r7 -> cnt=3, fourth write to r7 gets iss_ready=0; one wb r7 -> iss_ready=1.
REQ-024 SHALL cover simultaneous events: cnt[9]=1, accept write r9 plus wb r9 same cycle -> cnt[9] stays 1, busy_vec[9]=1.
REQ-025 SHALL cover R0 and out-of-range: write dest 0, src1=0, index >= NREG -> no counter changes, no hazard, busy_vec unchanged.
REQ-026 SHALL cover underflow and flush: wb r3 with cnt 0 -> err_underflow=1; counters nonzero then flush -> busy_vec=0, err_underflow=0 next cycle.
REQ-027 SHALL cover async reset mid-operation: busy_vec nonzero, resetn low between edges -> busy_vec=0 immediately, iss_ready=1.
